// File: rtl/afifo_pkg.sv
// Shared constants and types for the FWFT read adapter on the read side of the async FIFO.
package afifo_pkg;
  localparam int FWFT_DEPTH = 3;
  localparam int FWFT_PTR_W = 2;
  localparam int FWFT_OCC_W = 2;

  typedef logic [FWFT_PTR_W-1:0] ptr_t;
  typedef logic [FWFT_OCC_W-1:0] occ_t;

  // Pointers count 0 -> 1 -> 2 -> 0; code 3 is never used.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FWFT_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/afifo_fwft_buf.sv
// Three-entry circular buffer: captures one word per wr_en, presents the head word,
// and tracks occupancy. Storage is left unreset; only pointers and occupancy are reset.
module afifo_fwft_buf
  import afifo_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] head_o,
  output occ_t                 occ_o
);

  logic [DataWidth-1:0] mem_q [FWFT_DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  occ_t occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)   rd_ptr_d = ptr_inc(rd_ptr_q);
    // Simultaneous capture and pop leave occupancy unchanged.
    case ({wr_en_i, pop_i})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

  // The credit rule upstream must make a capture into a full buffer impossible.
  overflow_a: assert property (@(posedge clk_i) disable iff (srst_i)
    !(wr_en_i && !pop_i && (occ_q == occ_t'(FWFT_DEPTH))));

endmodule

// File: rtl/afifo_fwft_read_adapter.sv
// Read-domain adapter: issues credit-limited RDreq, captures RDdata one cycle after RDen,
// and re-presents the words as a first-word-fall-through valid/ready stream.
module afifo_fwft_read_adapter
  import afifo_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 RDclk,
  input  logic                 reset,
  input  logic                 FIFOempty,
  input  logic                 RDen,
  input  logic [DataWidth-1:0] RDdata,
  output logic                 RDreq,
  output logic [DataWidth-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [1:0]           Level
);

  logic       inflight_q, inflight_d;
  logic       pop;
  occ_t       occ;
  logic [2:0] credit_sum;
  logic       fifo_empty_unused;

  // The controller already gates RDreq with its empty flag, so only RDen matters here.
  assign fifo_empty_unused = FIFOempty;

  assign inflight_d = RDen;

  always_ff @(posedge RDclk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  afifo_fwft_buf #(
    .DataWidth (DataWidth)
  ) u_buf (
    .clk_i     (RDclk),
    .srst_i    (reset),
    .wr_en_i   (inflight_q),
    .wr_data_i (RDdata),
    .pop_i     (pop),
    .head_o    (OutData),
    .occ_o     (occ)
  );

  // Only registered terms feed the credit check, so OutReady never reaches RDreq.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight_q};
  assign RDreq      = !reset && (credit_sum < 3'(FWFT_DEPTH));

  assign OutValid = (occ != '0);
  assign pop      = OutValid && OutReady;
  assign Level    = occ;

endmodule

// File: tb/tb_afifo_fwft_read_adapter.sv
// Directed bench for afifo_fwft_read_adapter with a small controller/memory model.
module tb_afifo_fwft_read_adapter;

  logic       RDclk = 1'b0;
  logic       reset;
  logic       FIFOempty;
  logic       RDen;
  logic [7:0] RDdata;
  logic       RDreq;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady;
  logic [1:0] Level;

  logic       rd_gate;
  logic [7:0] src_mem [0:255];
  int         src_idx;
  int         pop_idx;
  int         vec_cnt;
  int         err_cnt;

  always #5 RDclk = ~RDclk;

  // Controller model: a grant happens only when requested and the FIFO holds data.
  assign RDen = rd_gate & RDreq & ~FIFOempty;

  afifo_fwft_read_adapter #(
    .DataWidth (8)
  ) dut (
    .RDclk     (RDclk),
    .reset     (reset),
    .FIFOempty (FIFOempty),
    .RDen      (RDen),
    .RDdata    (RDdata),
    .RDreq     (RDreq),
    .OutData   (OutData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Level     (Level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: checks a pop against the source order, models memory read latency,
  // and checks that a stalled head word stays put.
  task automatic tick();
    logic       fire;
    logic       held;
    logic [7:0] held_data;
    #2;
    if (OutValid && OutReady) begin
      chk("pop_data", {24'd0, OutData}, {24'd0, src_mem[pop_idx]});
      pop_idx++;
    end
    held      = OutValid & ~OutReady & ~reset;
    held_data = OutData;
    fire      = RDen;
    @(posedge RDclk);
    #1;
    if (fire) begin
      RDdata = src_mem[src_idx];
      src_idx++;
    end else begin
      RDdata = 8'hEE;
    end
    if (held) begin
      chk("hold_valid", {31'd0, OutValid}, 32'd1);
      chk("hold_data", {24'd0, OutData}, {24'd0, held_data});
    end
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    src_idx   = 0;
    pop_idx   = 0;
    reset     = 1'b1;
    FIFOempty = 1'b0;
    OutReady  = 1'b0;
    rd_gate   = 1'b0;
    RDdata    = 8'hEE;

    // Reset for two cycles
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_rdreq", {31'd0, RDreq}, 32'd0);
      chk("rst_valid", {31'd0, OutValid}, 32'd0);
      chk("rst_level", {30'd0, Level}, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("rst_release_rdreq", {31'd0, RDreq}, 32'd1);
    $display("reset sequence done");

    // Single word latency
    src_mem[0] = 8'hA5;
    src_idx = 0; pop_idx = 0;
    rd_gate = 1'b1;
    tick();
    rd_gate = 1'b0;
    chk("single_t1_valid", {31'd0, OutValid}, 32'd0);
    chk("single_t1_rdreq", {31'd0, RDreq}, 32'd1);
    tick();
    chk("single_t2_valid", {31'd0, OutValid}, 32'd1);
    chk("single_t2_data", {24'd0, OutData}, 32'hA5);
    chk("single_t2_level", {30'd0, Level}, 32'd1);
    OutReady = 1'b1;
    tick();
    chk("single_drained", {30'd0, Level}, 32'd0);
    chk("single_popped", pop_idx, 32'd1);
    OutReady = 1'b0;
    $display("single word 0xA5 done");

    // Ten-word stream at full rate
    for (int i = 0; i < 10; i++) src_mem[i] = 8'(i);
    src_idx = 0; pop_idx = 0;
    OutReady = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      rd_gate = (src_idx < 10);
      tick();
      chk("stream_valid", {31'd0, OutValid}, (c >= 2 && c <= 11) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 11) chk("stream_data", {24'd0, OutData}, 32'(c - 2));
    end
    chk("stream_count", pop_idx, 32'd10);
    $display("stream of 10 words done");

    // Backpressure fills the buffer, then release
    for (int i = 0; i < 6; i++) src_mem[i] = 8'h30 + 8'(i);
    src_idx = 0; pop_idx = 0;
    OutReady = 1'b0;
    rd_gate  = 1'b1;
    tick(); tick(); tick();
    chk("bp_e3_rdreq", {31'd0, RDreq}, 32'd0);
    tick();
    chk("bp_e4_level", {30'd0, Level}, 32'd3);
    chk("bp_e4_rdreq", {31'd0, RDreq}, 32'd0);
    tick();
    chk("bp_e5_level", {30'd0, Level}, 32'd3);
    chk("bp_e5_grants", src_idx, 32'd3);
    rd_gate  = (src_idx < 6);
    OutReady = 1'b1;
    #1;
    chk("bp_no_lookahead", {31'd0, RDreq}, 32'd0);
    tick();
    chk("bp_rdreq_back", {31'd0, RDreq}, 32'd1);
    chk("bp_level_after_pop", {30'd0, Level}, 32'd2);
    for (int c = 0; c < 10; c++) begin
      rd_gate = (src_idx < 6);
      tick();
    end
    chk("bp_all_popped", pop_idx, 32'd6);
    chk("bp_all_granted", src_idx, 32'd6);
    chk("bp_drained", {30'd0, Level}, 32'd0);
    $display("backpressure fill and release done");

    // Reset with two buffered words and one in flight
    for (int i = 0; i < 4; i++) src_mem[i] = 8'h50 + 8'(i);
    src_idx = 0; pop_idx = 0;
    OutReady = 1'b0;
    rd_gate  = 1'b1;
    tick(); tick(); tick();
    rd_gate = 1'b0;
    chk("rst2_pre_level", {30'd0, Level}, 32'd2);
    chk("rst2_pre_rdreq", {31'd0, RDreq}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_level", {30'd0, Level}, 32'd0);
    chk("rst2_valid", {31'd0, OutValid}, 32'd0);
    RDdata = 8'h77;
    tick();
    chk("rst2_no_capture_level", {30'd0, Level}, 32'd0);
    chk("rst2_rdreq", {31'd0, RDreq}, 32'd1);
    tick();
    chk("rst2_still_empty", {31'd0, OutValid}, 32'd0);
    $display("mid-operation reset done");

    // Random backpressure and empty flag, 200 words
    for (int i = 0; i < 200; i++) src_mem[i] = 8'($urandom);
    src_idx = 0; pop_idx = 0;
    for (int c = 0; c < 3000 && pop_idx < 200; c++) begin
      rd_gate   = (src_idx < 200);
      FIFOempty = ($urandom_range(0, 2) == 0);
      OutReady  = $urandom_range(0, 1) == 1;
      tick();
    end
    chk("rand_all_popped", pop_idx, 32'd200);
    chk("rand_all_granted", src_idx, 32'd200);
    chk("rand_drained", {30'd0, Level}, 32'd0);
    $display("random run of 200 words done");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
